line_burst_adaptor: RTL and testbench

Sits directly downstream of the I/D-cache arbiter, between its single pmem-side port and the physical memory model. Converts one cacheline request from the arbiter into a sequence of fixed-width memory bursts, and the bursts back into a full line. Reads are assembled beat by beat into line_o. Writes are latched whole and serialized onto burst_o. Exactly one request is outstanding at a time.

---
 rtl/line_burst_adaptor.sv | 130 +++++++++++++
 tb/tb_line_burst_adaptor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_burst_adaptor.sv
// Cacheline <-> memory burst adaptor between the cache arbiter and physical memory.
// Define ADAPTOR_FAST_RESP_EN to drop the DONE cycle and signal resp_o on the final beat.
module line_burst_adaptor #(
   parameter int unsigned LINE_W  = 256,
   parameter int unsigned BURST_W = 64,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic              read_i,
   input  logic              write_i,
   output logic              resp_o,
   output logic [ADDR_W-1:0]  address_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic              read_o,
   output logic              write_o,
   input  logic              resp_i
);

   localparam int unsigned BEATS = LINE_W / BURST_W;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned OFF_W = $clog2(LINE_W / 8);
   localparam logic [CNT_W-1:0]  LAST       = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [ADDR_W-1:0]  addr_reg;
   logic [LINE_W-1:0]  line_reg;
   logic [LINE_W-1:0]  wr_line;
   logic               last_beat;

   assign last_beat = ((state == READ) || (state == WRITE)) && resp_i && (count == LAST);
   assign address_o = addr_reg;
   assign burst_o   = wr_line[count*BURST_W +: BURST_W];

`ifndef ADAPTOR_FAST_RESP_EN
   logic resp_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         addr_reg <= '0;
         line_reg <= '0;
         wr_line  <= '0;
         read_o   <= 1'b0;
         write_o  <= 1'b0;
`ifndef ADAPTOR_FAST_RESP_EN
         resp_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               count <= '0;
               // A simultaneous read waits; the requester keeps read_i high until serviced.
               if (write_i) begin
                  state    <= WRITE;
                  write_o  <= 1'b1;
                  addr_reg <= address_i & ALIGN_MASK;
                  wr_line  <= line_i;
               end else if (read_i) begin
                  state    <= READ;
                  read_o   <= 1'b1;
                  addr_reg <= address_i & ALIGN_MASK;
               end
            end
            READ: begin
               if (resp_i) begin
                  line_reg[count*BURST_W +: BURST_W] <= burst_i;
               end
               if (last_beat) begin
                  count  <= '0;
                  read_o <= 1'b0;
`ifdef ADAPTOR_FAST_RESP_EN
                  state  <= IDLE;
`else
                  state  <= DONE;
                  resp_q <= 1'b1;
`endif
               end else if (resp_i) begin
                  count <= count + 1'b1;
               end
            end
            WRITE: begin
               if (last_beat) begin
                  count   <= '0;
                  write_o <= 1'b0;
`ifdef ADAPTOR_FAST_RESP_EN
                  state   <= IDLE;
`else
                  state   <= DONE;
                  resp_q  <= 1'b1;
`endif
               end else if (resp_i) begin
                  count <= count + 1'b1;
               end
            end
            default: begin
`ifndef ADAPTOR_FAST_RESP_EN
               resp_q <= 1'b0;
`endif
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ADAPTOR_FAST_RESP_EN
   // Final read beat bypasses the register so the line is complete alongside resp_o.
   always_comb begin
      line_o = line_reg;
      if ((state == READ) && last_beat) begin
         line_o[LINE_W-1 -: BURST_W] = burst_i;
      end
   end
   assign resp_o = last_beat;
`else
   assign line_o = line_reg;
   assign resp_o = resp_q;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Randomized self-checking bench for line_burst_adaptor against a transaction-level model.
// Honours ADAPTOR_FAST_RESP_EN to select the expected response timing.
module tb_line_burst_adaptor;

   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int ADDR_W  = 32;
   localparam int BEATS   = LINE_W / BURST_W;
   localparam logic [ADDR_W-1:0] ALIGN = 32'hFFFF_FFE0;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [ADDR_W-1:0]  address_i = '0;
   logic [LINE_W-1:0]  line_i = '0;
   logic [LINE_W-1:0]  line_o;
   logic               read_i = 1'b0;
   logic               write_i = 1'b0;
   logic               resp_o;
   logic [ADDR_W-1:0]  address_o;
   logic [BURST_W-1:0] burst_i = '0;
   logic [BURST_W-1:0] burst_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int resp_pat[$];
   logic [LINE_W-1:0] model_line = '0;

   line_burst_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .address_i(address_i), .line_i(line_i), .line_o(line_o),
      .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .address_o(address_o),
      .burst_i(burst_i), .burst_o(burst_o), .read_o(read_o), .write_o(write_o),
      .resp_i(resp_i)
   );

   always #5 clk = ~clk;

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [BURST_W-1:0] beat_of(input logic [LINE_W-1:0] l, input int i);
      return l[i*BURST_W +: BURST_W];
   endfunction

   // Previous line with the first k beats of the new line delivered.
   function automatic logic [LINE_W-1:0] partial(input logic [LINE_W-1:0] prev,
                                                 input logic [LINE_W-1:0] data, input int k);
      logic [LINE_W-1:0] r = prev;
      for (int j = 0; j < k; j++) r[j*BURST_W +: BURST_W] = data[j*BURST_W +: BURST_W];
      return r;
   endfunction

   function automatic logic next_resp(input int stall_pct);
      int v;
      if (resp_pat.size() > 0) begin
         v = resp_pat.pop_front();
         return v != 0;
      end
      return $urandom_range(99) >= stall_pct;
   endfunction

   task automatic test_reset();
      rst = 1'b1; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b1;
      address_i = $urandom; line_i = rand_line(); burst_i = {$urandom, $urandom};
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (read_o !== 1'b0) begin miscompares++; $display("FAIL rst_read_o got %b exp 0", read_o); end
      vectors++; if (write_o !== 1'b0) begin miscompares++; $display("FAIL rst_write_o got %b exp 0", write_o); end
      vectors++; if (resp_o !== 1'b0) begin miscompares++; $display("FAIL rst_resp_o got %b exp 0", resp_o); end
      vectors++; if (address_o !== '0) begin miscompares++; $display("FAIL rst_address_o got %h exp 0", address_o); end
      vectors++; if (burst_o !== '0) begin miscompares++; $display("FAIL rst_burst_o got %h exp 0", burst_o); end
      vectors++; if (line_o !== '0) begin miscompares++; $display("FAIL rst_line_o got %h exp 0", line_o); end
      @(negedge clk);
      rst = 1'b0; read_i = 1'b0; resp_i = 1'b0;
      model_line = '0;
   endtask

   task automatic test_idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         read_i = 1'b0; write_i = 1'b0; resp_i = $urandom_range(1);
         burst_i = {$urandom, $urandom}; address_i = $urandom;
         #1;
         vectors++; if (resp_o !== 1'b0) begin miscompares++; $display("FAIL idle_resp_o got %b exp 0", resp_o); end
         vectors++; if ({read_o, write_o} !== 2'b00) begin miscompares++; $display("FAIL idle_req got %b exp 00", {read_o, write_o}); end
         vectors++; if (line_o !== model_line) begin miscompares++; $display("FAIL idle_line_o got %h exp %h", line_o, model_line); end
      end
   endtask

   task automatic test_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                            input int stall_pct);
      logic [ADDR_W-1:0] exp_addr = addr & ALIGN;
      logic [LINE_W-1:0] exp_line;
      int k = 0;
      logic r, exp_resp;
      bit done = 0;
      @(negedge clk);
      read_i = 1'b1; write_i = 1'b0; address_i = addr; line_i = rand_line();
      resp_i = $urandom_range(1); burst_i = {$urandom, $urandom};
      #1;
      vectors++; if ({read_o, write_o, resp_o} !== 3'b000) begin miscompares++; $display("FAIL rd_idle got %b exp 000", {read_o, write_o, resp_o}); end
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         address_i = $urandom; line_i = rand_line();
         if (k < BEATS) begin
            r = next_resp(stall_pct);
            resp_i = r;
            burst_i = r ? beat_of(data, k) : {$urandom, $urandom};
         end else begin
            r = 1'b0;
            resp_i = $urandom_range(1);
            burst_i = {$urandom, $urandom};
         end
         #1;
         if (k < BEATS) begin
            vectors++; if (read_o !== 1'b1) begin miscompares++; $display("FAIL rd_read_o beat %0d got %b exp 1", k, read_o); end
            vectors++; if (write_o !== 1'b0) begin miscompares++; $display("FAIL rd_write_o got %b exp 0", write_o); end
            vectors++; if (address_o !== exp_addr) begin miscompares++; $display("FAIL rd_address_o got %h exp %h", address_o, exp_addr); end
`ifdef ADAPTOR_FAST_RESP_EN
            exp_resp = r && (k == BEATS - 1);
            exp_line = exp_resp ? data : partial(model_line, data, k);
            if (exp_resp) done = 1;
`else
            exp_resp = 1'b0;
            exp_line = partial(model_line, data, k);
`endif
            vectors++; if (resp_o !== exp_resp) begin miscompares++; $display("FAIL rd_resp_o beat %0d got %b exp %b", k, resp_o, exp_resp); end
            vectors++; if (line_o !== exp_line) begin miscompares++; $display("FAIL rd_line_o beat %0d got %h exp %h", k, line_o, exp_line); end
            if (r) k++;
         end else begin
            vectors++; if ({read_o, write_o} !== 2'b00) begin miscompares++; $display("FAIL rd_done_req got %b exp 00", {read_o, write_o}); end
            vectors++; if (resp_o !== 1'b1) begin miscompares++; $display("FAIL rd_done_resp_o got %b exp 1", resp_o); end
            vectors++; if (line_o !== data) begin miscompares++; $display("FAIL rd_done_line_o got %h exp %h", line_o, data); end
            done = 1;
         end
      end
      if (!done) begin
         vectors++; miscompares++;
         $display("FAIL rd_timeout got %0d beats exp %0d with resp_o", k, BEATS);
      end
      model_line = data;
   endtask

   task automatic test_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                             input int stall_pct, input logic with_read);
      logic [ADDR_W-1:0] exp_addr = addr & ALIGN;
      int k = 0;
      logic r, exp_resp;
      bit done = 0;
      @(negedge clk);
      write_i = 1'b1; read_i = with_read; address_i = addr; line_i = data;
      resp_i = $urandom_range(1); burst_i = {$urandom, $urandom};
      #1;
      vectors++; if ({read_o, write_o, resp_o} !== 3'b000) begin miscompares++; $display("FAIL wr_idle got %b exp 000", {read_o, write_o, resp_o}); end
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         address_i = $urandom; line_i = rand_line(); burst_i = {$urandom, $urandom};
         if (k < BEATS) begin
            r = next_resp(stall_pct);
            resp_i = r;
         end else begin
            r = 1'b0;
            resp_i = $urandom_range(1);
         end
         #1;
         if (k < BEATS) begin
            vectors++; if (write_o !== 1'b1) begin miscompares++; $display("FAIL wr_write_o beat %0d got %b exp 1", k, write_o); end
            vectors++; if (read_o !== 1'b0) begin miscompares++; $display("FAIL wr_read_o got %b exp 0", read_o); end
            vectors++; if (address_o !== exp_addr) begin miscompares++; $display("FAIL wr_address_o got %h exp %h", address_o, exp_addr); end
            vectors++; if (burst_o !== beat_of(data, k)) begin miscompares++; $display("FAIL wr_burst_o beat %0d got %h exp %h", k, burst_o, beat_of(data, k)); end
            vectors++; if (line_o !== model_line) begin miscompares++; $display("FAIL wr_line_o_hold got %h exp %h", line_o, model_line); end
`ifdef ADAPTOR_FAST_RESP_EN
            exp_resp = r && (k == BEATS - 1);
            if (exp_resp) done = 1;
`else
            exp_resp = 1'b0;
`endif
            vectors++; if (resp_o !== exp_resp) begin miscompares++; $display("FAIL wr_resp_o beat %0d got %b exp %b", k, resp_o, exp_resp); end
            if (r) k++;
         end else begin
            vectors++; if ({read_o, write_o} !== 2'b00) begin miscompares++; $display("FAIL wr_done_req got %b exp 00", {read_o, write_o}); end
            vectors++; if (resp_o !== 1'b1) begin miscompares++; $display("FAIL wr_done_resp_o got %b exp 1", resp_o); end
            vectors++; if (line_o !== model_line) begin miscompares++; $display("FAIL wr_done_line_o got %h exp %h", line_o, model_line); end
            done = 1;
         end
      end
      if (!done) begin
         vectors++; miscompares++;
         $display("FAIL wr_timeout got %0d beats exp %0d with resp_o", k, BEATS);
      end
   endtask

   task automatic test_read_immediate();
      logic [LINE_W-1:0] l;
      l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      test_read(32'h0000_1234, l, 0);
   endtask

   task automatic test_write_stalls();
      logic [LINE_W-1:0] l;
      l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
      resp_pat = '{1, 0, 0, 1, 1, 0, 1};
      test_write(32'h0000_8047, l, 0, 1'b0);
   endtask

   task automatic test_priority();
      test_write($urandom, rand_line(), 30, 1'b1);
      test_read($urandom, rand_line(), 30);
   endtask

   task automatic test_back_to_back();
      test_read($urandom, rand_line(), 0);
      test_idle(1);
      test_write($urandom, rand_line(), 20, 1'b0);
      test_idle(1);
   endtask

   task automatic test_reset_mid_read();
      logic [LINE_W-1:0] l = rand_line();
      @(negedge clk);
      read_i = 1'b1; write_i = 1'b0; address_i = $urandom; resp_i = 1'b0;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         resp_i = 1'b1; burst_i = beat_of(l, b);
      end
      @(negedge clk);
      rst = 1'b1; resp_i = 1'b1; burst_i = beat_of(l, 2);
      @(negedge clk);
      rst = 1'b0; read_i = 1'b0; resp_i = 1'b0;
      #1;
      vectors++; if ({read_o, write_o, resp_o} !== 3'b000) begin miscompares++; $display("FAIL mid_rst_ctrl got %b exp 000", {read_o, write_o, resp_o}); end
      vectors++; if (line_o !== '0) begin miscompares++; $display("FAIL mid_rst_line_o got %h exp 0", line_o); end
      vectors++; if (address_o !== '0) begin miscompares++; $display("FAIL mid_rst_address_o got %h exp 0", address_o); end
      model_line = '0;
      test_read($urandom, rand_line(), 40);
   endtask

   task automatic test_random_mix();
      repeat (8) begin
         if ($urandom_range(1) == 1) test_write($urandom, rand_line(), $urandom_range(60), 1'b0);
         else test_read($urandom, rand_line(), $urandom_range(60));
         test_idle($urandom_range(2));
      end
   endtask

   initial begin
      test_reset();
      test_read_immediate();
      test_write_stalls();
      test_priority();
      test_back_to_back();
      test_reset_mid_read();
      test_idle(5);
      test_random_mix();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
